// File: rtl/drap_dmem_arbiter.sv
// drap_dmem_arbiter: shares one DRAP data-memory port between two requesters, one access per 3 cycles.
// Round-robin by default; defining DRAP_ARB_FIXED_PRIO_EN makes port 0 always win a tie.
module drap_dmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic   grant, last_grant, pick1, win_we;

`ifdef DRAP_ARB_FIXED_PRIO_EN
    assign pick1 = p1_req & ~p0_req;
`else
    assign pick1 = p1_req & (~p0_req | ~last_grant);
`endif
    assign win_we   = pick1 ? p1_we : p0_we;
    assign busy     = state != IDLE;
    assign p0_rdata = mem_rdata;
    assign p1_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: if (p0_req | p1_req) begin
                    grant     <= pick1;
                    mem_addr  <= pick1 ? p1_addr : p0_addr;
                    mem_wdata <= pick1 ? p1_wdata : p0_wdata;
                    mem_write <= win_we;
                    mem_read  <= ~win_we;
                    state     <= ACCESS;
                end
                // memory performs the operation on the edge leaving ACCESS
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    p0_ack    <= ~grant;
                    p1_ack    <= grant;
                    state     <= DONE;
                end
                DONE: begin
                    p0_ack     <= 1'b0;
                    p1_ack     <= 1'b0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
